// File: rtl/wfifo_burst_drain.sv
// Drains a prefetch FIFO into a local burst buffer and replays it as fixed-length AXI4 write bursts.
// Optional AXI watchdog: define WFIFO_DRAIN_WDOG_EN.
module wfifo_burst_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 28,
   parameter int BURST_LEN  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN = 28'h0100000
) (
   input  logic                      rd_clk,
   input  logic                      rd_rst,
   input  logic                      enable,
   output logic                      fifo_rd_en,
   input  logic                      fifo_rd_vld,
   input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
   output logic [ADDR_WIDTH-1:0]     awaddr,
   output logic [7:0]                awlen,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH/8-1:0]   wstrb,
   output logic                      wlast,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   output logic                      busy,
   output logic [31:0]               burst_cnt,
   output logic                      err
);

   localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] END_ADDR    = BASE_ADDR + ADDR_SPAN;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_FILL = 3'd1;
   localparam logic [2:0] ST_AW   = 3'd2;
   localparam logic [2:0] ST_W    = 3'd3;
   localparam logic [2:0] ST_B    = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
   logic [IDX_W-1:0]      fill_idx_q, fill_idx_d;
   logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
   logic [IDX_W-1:0]      rd_addr;
   logic [31:0]           burst_cnt_q, burst_cnt_d;
   logic                  err_q, err_d;
   logic                  buf_we;
   logic [DATA_WIDTH-1:0] buf_q [BURST_LEN];
   logic [DATA_WIDTH-1:0] wdata_q;
`ifdef WFIFO_DRAIN_WDOG_EN
   logic [15:0]           wdog_q, wdog_d;
   logic                  lock_q, lock_d;
   logic                  axi_hs;
`endif

   assign addr_inc = addr_q + BURST_BYTES;
   assign buf_we   = (state_q == ST_FILL) && fifo_rd_vld;
   // Prefetch the next beat so the registered RAM read lines up with the handshake.
   assign rd_addr  = (state_q == ST_W && wready) ? beat_idx_q + 1'b1 :
                     (state_q == ST_W)           ? beat_idx_q : '0;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      fill_idx_d  = fill_idx_q;
      beat_idx_d  = beat_idx_q;
      burst_cnt_d = burst_cnt_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
`ifdef WFIFO_DRAIN_WDOG_EN
            if (enable && !lock_q) state_d = ST_FILL;
`else
            if (enable) state_d = ST_FILL;
`endif
            fill_idx_d = '0;
         end
         ST_FILL: begin
            if (fifo_rd_vld) begin
               fill_idx_d = fill_idx_q + 1'b1;
               if (fill_idx_q == LAST_IDX) begin
                  fill_idx_d = '0;
                  state_d    = ST_AW;
               end
            end
         end
         ST_AW: begin
            if (awready) begin
               beat_idx_d = '0;
               state_d    = ST_W;
            end
         end
         ST_W: begin
            if (wready) begin
               beat_idx_d = beat_idx_q + 1'b1;
               if (beat_idx_q == LAST_IDX) state_d = ST_B;
            end
         end
         ST_B: begin
            if (bvalid) begin
               burst_cnt_d = burst_cnt_q + 32'd1;
               if (bresp != 2'b00) err_d = 1'b1;
               addr_d  = (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;
               state_d = enable ? ST_FILL : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef WFIFO_DRAIN_WDOG_EN
      lock_d = lock_q;
      axi_hs = (state_q == ST_AW && awready) || (state_q == ST_W && wready) ||
               (state_q == ST_B && bvalid);
      wdog_d = '0;
      if (state_q == ST_AW || state_q == ST_W || state_q == ST_B) begin
         wdog_d = axi_hs ? 16'd0 : wdog_q + 16'd1;
         // A timed-out burst is abandoned without touching address or count.
         if (!axi_hs && wdog_q == 16'hFFFF) begin
            err_d       = 1'b1;
            lock_d      = 1'b1;
            state_d     = ST_IDLE;
            addr_d      = addr_q;
            burst_cnt_d = burst_cnt_q;
            wdog_d      = '0;
         end
      end
`endif
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= BASE_ADDR;
         fill_idx_q  <= '0;
         beat_idx_q  <= '0;
         burst_cnt_q <= '0;
         err_q       <= 1'b0;
`ifdef WFIFO_DRAIN_WDOG_EN
         wdog_q      <= '0;
         lock_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         fill_idx_q  <= fill_idx_d;
         beat_idx_q  <= beat_idx_d;
         burst_cnt_q <= burst_cnt_d;
         err_q       <= err_d;
`ifdef WFIFO_DRAIN_WDOG_EN
         wdog_q      <= wdog_d;
         lock_q      <= lock_d;
`endif
      end
   end

   // Burst buffer: no reset so it maps onto block RAM.
   always_ff @(posedge rd_clk) begin
      if (buf_we) buf_q[fill_idx_q] <= fifo_rd_data;
      wdata_q <= buf_q[rd_addr];
   end

   assign fifo_rd_en = (state_q == ST_FILL);
   assign awaddr     = addr_q;
   assign awlen      = 8'(BURST_LEN - 1);
   assign awvalid    = (state_q == ST_AW);
   assign wvalid     = (state_q == ST_W);
   assign wdata      = wdata_q;
   assign wstrb      = '1;
   assign wlast      = (state_q == ST_W) && (beat_idx_q == LAST_IDX);
   assign bready     = (state_q == ST_B);
   assign busy       = (state_q != ST_IDLE);
   assign burst_cnt  = burst_cnt_q;
   assign err        = err_q;

endmodule

// File: tb/tb_wfifo_burst_drain.sv
// Directed bench: a table of per-burst scenarios plus a hand-written mid-burst reset sequence.
module tb_wfifo_burst_drain;

   logic        rd_clk = 1'b0;
   logic        rd_rst, enable;
   logic        fifo_rd_vld;
   logic [31:0] fifo_rd_data;
   logic        awready, wready, bvalid;
   logic [1:0]  bresp;

   logic        fifo_rd_en, awvalid, wvalid, wlast, bready, busy, err;
   logic [27:0] awaddr;
   logic [7:0]  awlen;
   logic [31:0] wdata, burst_cnt;
   logic [3:0]  wstrb;

   logic        fifo_rd_en_w, awvalid_w, wvalid_w, wlast_w, bready_w, busy_w, err_w;
   logic [27:0] awaddr_w;
   logic [7:0]  awlen_w;
   logic [31:0] wdata_w, burst_cnt_w;
   logic [3:0]  wstrb_w;

   always #5 rd_clk = ~rd_clk;

   wfifo_burst_drain dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
      .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .busy(busy), .burst_cnt(burst_cnt), .err(err)
   );

   wfifo_burst_drain #(.ADDR_SPAN(28'h80)) dut_w (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
      .fifo_rd_en(fifo_rd_en_w), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
      .awaddr(awaddr_w), .awlen(awlen_w), .awvalid(awvalid_w), .awready(awready),
      .wdata(wdata_w), .wstrb(wstrb_w), .wlast(wlast_w), .wvalid(wvalid_w), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready_w),
      .busy(busy_w), .burst_cnt(burst_cnt_w), .err(err_w)
   );

   typedef struct {
      bit          toggle;
      int          aw_delay;
      int          stall_beat;
      int          stall_cyc;
      logic [1:0]  resp;
      bit          drop_en;
      logic [27:0] exp_addr;
      logic [27:0] exp_addr_w;
      logic [31:0] exp_cnt;
      bit          exp_err;
   } vec_t;

   vec_t        vecs[5];
   int          n_checks = 0;
   int          n_err = 0;
   int          seq = 0;
   int          pops = 0;
   logic [31:0] exp_words[16];

   function automatic logic [31:0] word_of(input int s);
      return 32'hA500_0000 ^ (32'(s) * 32'h0001_0003);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      bit pop;
      pop = (fifo_rd_en === 1'b1) && (fifo_rd_vld === 1'b1);
      @(posedge rd_clk);
      #1;
      if (pop) begin
         if (pops < 16) exp_words[pops] = fifo_rd_data;
         pops++;
         seq++;
         fifo_rd_data = word_of(seq);
      end
   endtask

   task automatic run_burst(input int i);
      vec_t v;
      v = vecs[i];
      pops = 0;
      for (int c = 0; c < 200 && pops < 16; c++) begin
         fifo_rd_vld = v.toggle ? (c % 2 == 0) : 1'b1;
         tick();
      end
      fifo_rd_vld = 1'b1;
      check("fill_pops", 64'(pops), 64'd16);
      check("rd_en_drop", 64'(fifo_rd_en), 64'd0);
      check("aw_latency", 64'(awvalid), 64'd1);
      for (int d = 0; d < v.aw_delay; d++) begin
         awready = 1'b0;
         check("aw_hold_valid", 64'(awvalid), 64'd1);
         check("aw_hold_addr", 64'(awaddr), 64'(v.exp_addr));
         tick();
      end
      awready = 1'b1;
      check("awvalid", 64'(awvalid), 64'd1);
      check("awaddr", 64'(awaddr), 64'(v.exp_addr));
      check("awaddr_wrap", 64'(awaddr_w), 64'(v.exp_addr_w));
      check("awlen", 64'(awlen), 64'd15);
      tick();
      for (int b = 0; b < 16; b++) begin
         if (b == v.stall_beat) begin
            for (int s = 0; s < v.stall_cyc; s++) begin
               wready = 1'b0;
               check("stall_wvalid", 64'(wvalid), 64'd1);
               check("stall_wdata", 64'(wdata), 64'(exp_words[b]));
               check("stall_wlast", 64'(wlast), 64'd0);
               tick();
            end
         end
         wready = 1'b1;
         if (v.drop_en && b == 3) enable = 1'b0;
         check("wvalid", 64'(wvalid), 64'd1);
         check("wdata", 64'(wdata), 64'(exp_words[b]));
         check("wlast", 64'(wlast), 64'(b == 15));
         tick();
      end
      check("beats_total", 64'(wvalid), 64'd0);
      check("bready", 64'(bready), 64'd1);
      bresp = v.resp;
      tick();
      bresp = 2'b00;
      check("burst_cnt", 64'(burst_cnt), 64'(v.exp_cnt));
      check("burst_cnt_wrap", 64'(burst_cnt_w), 64'(v.exp_cnt));
      check("err", 64'(err), 64'(v.exp_err));
      if (v.drop_en) begin
         check("idle_after_drop", 64'(busy), 64'd0);
         tick();
         tick();
         check("idle_hold_busy", 64'(busy), 64'd0);
         check("idle_hold_rd_en", 64'(fifo_rd_en), 64'd0);
      end else begin
         check("refill_busy", 64'(busy), 64'd1);
         check("refill_rd_en", 64'(fifo_rd_en), 64'd1);
      end
   endtask

   initial begin
      //         toggle aw_dly stall_b stall_c resp   drop  addr      addr_w   cnt    err
      vecs[0] = '{1'b0, 0,     -1,     0,      2'b00, 1'b0, 28'h000,  28'h00,  32'd1, 1'b0};
      vecs[1] = '{1'b1, 0,     -1,     0,      2'b10, 1'b0, 28'h040,  28'h40,  32'd2, 1'b1};
      vecs[2] = '{1'b0, 4,      5,     3,      2'b00, 1'b0, 28'h080,  28'h00,  32'd3, 1'b1};
      vecs[3] = '{1'b0, 0,     -1,     0,      2'b00, 1'b0, 28'h0C0,  28'h40,  32'd4, 1'b1};
      vecs[4] = '{1'b0, 0,     -1,     0,      2'b00, 1'b1, 28'h100,  28'h00,  32'd5, 1'b1};

      rd_rst = 1'b1; enable = 1'b0; fifo_rd_vld = 1'b0; fifo_rd_data = word_of(0);
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      check("rst_awvalid", 64'(awvalid), 64'd0);
      check("rst_wvalid", 64'(wvalid), 64'd0);
      check("rst_wlast", 64'(wlast), 64'd0);
      check("rst_bready", 64'(bready), 64'd0);
      check("rst_burst_cnt", 64'(burst_cnt), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_awaddr", 64'(awaddr), 64'd0);
      check("wstrb", 64'(wstrb), 64'hF);

      rd_rst = 1'b0;
      tick();
      check("idle_no_enable", 64'(busy), 64'd0);
      enable = 1'b1;
      tick();
      check("fill_busy", 64'(busy), 64'd1);
      check("fill_rd_en", 64'(fifo_rd_en), 64'd1);

      for (int i = 0; i < 5; i++) run_burst(i);

      // Reset in the middle of the W phase of a fresh burst.
      enable = 1'b1;
      fifo_rd_vld = 1'b1;
      pops = 0;
      for (int c = 0; c < 300 && wvalid !== 1'b1; c++) tick();
      check("reach_w", 64'(wvalid), 64'd1);
      tick();
      tick();
      tick();
      check("pre_rst_awaddr", 64'(awaddr), 64'h140);
      rd_rst = 1'b1;
      tick();
      check("midw_rst_wvalid", 64'(wvalid), 64'd0);
      check("midw_rst_busy", 64'(busy), 64'd0);
      check("midw_rst_cnt", 64'(burst_cnt), 64'd0);
      check("midw_rst_awaddr", 64'(awaddr), 64'd0);
      check("midw_rst_err", 64'(err), 64'd0);
      check("midw_rst_rd_en", 64'(fifo_rd_en), 64'd0);
      rd_rst = 1'b0;
      enable = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/wfifo_burst_drain.md
Name: wfifo_burst_drain

Overview:
- Read-side consumer of the write-path prefetch FIFO. Pulls samples through the FIFO's rd_en/rd_vld handshake and stages them locally.
- Emits fixed-length AXI4-style write bursts toward the DDR controller.
- Sits between the ADC capture FIFO and the DDR write port, and runs in the FIFO read-clock domain.

Parameters:
- DATA_WIDTH, 32, FIFO word and AXI data width in bits. Allowed values: 32, 64, 128, 256.
- ADDR_WIDTH, 28, AXI byte-address width.
- BURST_LEN, 16, beats per burst. Allowed values: 2 to 256, power of two.
- BASE_ADDR, 0, first burst byte address. Must be aligned to BURST_LEN*DATA_WIDTH/8.
- ADDR_SPAN, 28'h0100000, ring size in bytes. Must be a multiple of the burst byte size.

Ports:
- rd_clk  in  1  single clock; all logic is on the rising edge.
- rd_rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = keep draining; 0 = stop after the current burst.
- fifo_rd_en  out  1  pop request to the prefetch FIFO.
- fifo_rd_vld  in  1  FIFO output word is valid.
- fifo_rd_data  in  DATA_WIDTH  FIFO output word.
- awaddr  out  ADDR_WIDTH  burst start byte address.
- awlen  out  8  constant BURST_LEN-1.
- awvalid  out  1  write-address valid.
- awready  in  1  write-address ready.
- wdata  out  DATA_WIDTH  write data.
- wstrb  out  DATA_WIDTH/8  all ones.
- wlast  out  1  last beat of the burst.
- wvalid  out  1  write-data valid.
- wready  in  1  write-data ready.
- bresp  in  2  write response code.
- bvalid  in  1  write-response valid.
- bready  out  1  write-response ready.
- busy  out  1  state is not IDLE.
- burst_cnt  out  32  completed bursts; wraps modulo 2^32.
- err  out  1  sticky error flag, cleared only by rd_rst.

Behaviour:
- Reset (rd_rst=1 at a clock edge): state=IDLE, addr=BASE_ADDR, fill/beat counters=0, burst_cnt=0, err=0. All valid/ready/enable outputs are 0 and wlast=0.
- A reset that arrives mid-burst aborts immediately. The partial burst is dropped and words already in the buffer are lost.
- FIFO handshake: a word transfers on any edge where fifo_rd_en=1 and fifo_rd_vld=1.
  - fifo_rd_en is registered and asserted only in FILL.
  - fifo_rd_en drops on the same edge the BURST_LEN-th word is captured, so no extra pop occurs.
- Local buffer: BURST_LEN x DATA_WIDTH, written at fill_idx and read at beat_idx.
- IDLE: when enable=1, go to FILL.
- FILL:
  - fifo_rd_en=1; capture each transferred word.
  - When fill_idx reaches BURST_LEN-1 on a transfer, go to AW. If fifo_rd_vld=0, stay in FILL indefinitely.
- AW:
  - awvalid=1 with awaddr=addr; hold stable until awready.
  - On awvalid&awready, go to W (earliest beat: next cycle).
- W:
  - wvalid=1 and wdata=buf[beat_idx]; beat_idx advances on wvalid&wready.
  - wlast=1 exactly when beat_idx=BURST_LEN-1.
  - A beat with wready=0 holds wdata/wlast stable.
  - After the last beat is accepted, go to B.
- B:
  - bready=1.
  - On bvalid: burst_cnt+1. If bresp!=2'b00, set err=1.
  - Address update: addr += BURST_LEN*DATA_WIDTH/8. If the result equals BASE_ADDR+ADDR_SPAN, load BASE_ADDR instead (ring wrap).
  - Next state: FILL if enable=1, else IDLE.
- enable=0 in any non-IDLE state has no effect until the B completion; bursts are never partial.
- Latency: the first awvalid appears 1 cycle after the BURST_LEN-th word transfer. The minimum burst period is BURST_LEN (fill) + 1 (AW) + BURST_LEN (W) + 1 (B) cycles.

Optional Feature:
- Macro: WFIFO_DRAIN_WDOG_EN.
- Defined:
  - A 16-bit counter runs in AW, W and B; it reloads on every AW handshake, W handshake and bvalid.
  - If it reaches 16'hFFFF: set err=1, drop all valid/ready outputs, and go to IDLE.
  - The address does not advance; burst_cnt is unchanged.
  - IDLE is then held until rd_rst, even with enable=1.
- Undefined: no counter; the block waits on AXI handshakes forever, and err is set only by bresp.

Test Plan:
- Reset then enable=1, FIFO always valid, awready/wready/bvalid tied 1, BURST_LEN=16, DATA_WIDTH=32:
  - Expect awaddr 0x0, 0x40, 0x80 on successive bursts.
  - wdata must equal the FIFO sequence in order, with wlast on every 16th beat.
  - burst_cnt increments by 1 per bresp.
- FIFO vld toggling 1/0 each cycle during FILL:
  - Exactly 16 pops occur; fifo_rd_en=0 in the cycle after the 16th pop.
  - No word is duplicated or lost.
- wready low for 3 cycles on beat 5, and awready delayed 4 cycles:
  - awaddr/awvalid stay stable while waiting for awready.
  - wdata/wlast hold during the stall; total beats=16.
- ADDR_SPAN=0x80: third burst awaddr=0x0 after 0x0 and 0x40.
- bresp=2'b10 on burst 2: err=1 stays set, burst_cnt=2, and bursts continue.
- Either of two conditions:
  - enable dropped during W of burst 1: the burst completes, then IDLE, busy=0.
  - rd_rst asserted mid-W: next cycle wvalid=0, state IDLE, burst_cnt=0, awaddr=BASE_ADDR.
